// File: rtl/int_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : int_wb_pkg
// Brief  : Shared writeback source ids and scoreboard count types.
// Rev    : 1.0
// ============================================================================
package int_wb_pkg;

  localparam int SRC_ALU    = 0;
  localparam int SRC_LSU    = 1;
  localparam int SRC_MULDIV = 2;
  localparam int SRC_CSR    = 3;
  localparam int NUM_WB_SRC = 4;

  typedef logic [1:0] pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = 2'd3;

endpackage
`default_nettype wire

// File: rtl/int_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : int_wb_arbiter_if
// Brief  : Writeback request bus and register-file write port bundle.
// Rev    : 1.0
// ============================================================================
interface int_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int ADDR_W     = 5
);

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*ADDR_W-1:0]     src_rd_addr;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_rd_data;
  logic [ADDR_W-1:0]             rf_rd_addr;
  logic [DATA_WIDTH-1:0]         rf_rd_data;
  logic                          rf_rd_write;

  modport master (
    output src_valid, src_rd_addr, src_rd_data,
    input  src_ready, rf_rd_addr, rf_rd_data, rf_rd_write
  );

  modport slave (
    input  src_valid, src_rd_addr, src_rd_data,
    output src_ready, rf_rd_addr, rf_rd_data, rf_rd_write
  );

endinterface
`default_nettype wire

// File: rtl/int_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter; pointer moves past the winner on advance.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  wire logic                                        clk,
  input  wire logic                                        rst_n,
  input  wire logic [NUM_REQ-1:0]                          req,
  input  wire logic                                        advance,
  output logic      [NUM_REQ-1:0]                          grant,
  output logic      [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_IDX_W-1:0] r_ptr;
  logic [c_IDX_W-1:0] w_kidx;
  logic               w_found;
  int                 w_k;

  // Scan from r_ptr with an explicit wrap so NUM_REQ need not be a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    w_kidx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = int'(r_ptr) + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      w_kidx = c_IDX_W'(w_k);
      if (!w_found && req[w_kidx]) begin
        w_found       = 1'b1;
        grant[w_kidx] = 1'b1;
        grant_idx     = w_kidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (grant_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : int_wb_arbiter
// Brief  : Integer writeback arbiter with per-register pending-write scoreboard.
// Rev    : 1.0
// ============================================================================
module int_wb_arbiter
  import int_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = NUM_WB_SRC,
  parameter int REG_NUM    = 32
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  int_wb_arbiter_if.slave                 bus,
  input  wire logic                       issue_valid,
  input  wire logic [$clog2(REG_NUM)-1:0] issue_rd_addr,
  output logic                            issue_ready,
  input  wire logic [$clog2(REG_NUM)-1:0] rs1_addr,
  input  wire logic [$clog2(REG_NUM)-1:0] rs2_addr,
  output logic                            rs1_busy,
  output logic                            rs2_busy,
  output logic                            rd_busy,
  input  wire logic                       flush
);

  localparam int c_ADDR_W = $clog2(REG_NUM);
  localparam int c_IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]  w_grant;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_hs;
  logic [c_ADDR_W-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [REG_NUM-1:0]  w_inc;
  logic [REG_NUM-1:0]  w_dec;
  pend_cnt_t           r_cnt [REG_NUM];

  rr_arbiter #(
    .NUM_REQ (NUM_SRC)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.src_valid),
    .advance   (w_hs),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  assign bus.src_ready = w_grant;
  assign w_hs          = |(bus.src_valid & w_grant);
  assign w_sel_addr    = bus.src_rd_addr[w_idx*c_ADDR_W +: c_ADDR_W];
  assign w_sel_data    = bus.src_rd_data[w_idx*DATA_WIDTH +: DATA_WIDTH];

  // Writes to x0 are consumed but never reach the file or the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_rd_write <= 1'b0;
      bus.rf_rd_addr  <= '0;
      bus.rf_rd_data  <= '0;
    end else begin
      bus.rf_rd_write <= w_hs && (w_sel_addr != '0);
      if (w_hs) begin
        bus.rf_rd_addr <= w_sel_addr;
        bus.rf_rd_data <= w_sel_data;
      end
    end
  end

  assign issue_ready = (r_cnt[issue_rd_addr] != PEND_MAX);
  assign rs1_busy    = (r_cnt[rs1_addr] != '0);
  assign rs2_busy    = (r_cnt[rs2_addr] != '0);
  assign rd_busy     = (r_cnt[issue_rd_addr] != '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    w_inc[issue_rd_addr]  = issue_valid & issue_ready & ~flush & (issue_rd_addr != '0);
    w_dec[bus.rf_rd_addr] = bus.rf_rd_write;
  end

  // A decrement at zero is dropped; this also covers commits landing after a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (r == 0 || flush) begin
          r_cnt[r] <= '0;
        end else if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + 1'b1;
        end else if (w_dec[r] && !w_inc[r] && r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_int_wb_arbiter
// Brief  : Directed bench for the writeback arbiter and pending scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_int_wb_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int AW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid;
  logic [4:0] issue_rd_addr;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       flush;
  logic       issue_ready;
  logic       rs1_busy;
  logic       rs2_busy;
  logic       rd_busy;

  always #5 clk = ~clk;

  int_wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .ADDR_W(AW)) bus ();

  int_wb_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .REG_NUM(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .issue_valid   (issue_valid),
    .issue_rd_addr (issue_rd_addr),
    .issue_ready   (issue_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd_busy       (rd_busy),
    .flush         (flush)
  );

  typedef struct {
    logic [3:0]   sv;
    logic [19:0]  sa;
    logic [127:0] sd;
    logic [3:0]   e_rdy;
    logic         e_wr;
    logic [4:0]   e_addr;
    logic [31:0]  e_data;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.src_valid   = '0;
    bus.src_rd_addr = '0;
    bus.src_rd_data = '0;
    issue_valid     = 1'b0;
    issue_rd_addr   = '0;
    rs1_addr        = '0;
    rs2_addr        = '0;
    flush           = 1'b0;
  endtask

  task automatic src(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.src_valid[i]           = 1'b1;
    bus.src_rd_addr[i*AW +: AW] = a;
    bus.src_rd_data[i*DW +: DW] = d;
  endtask

  task automatic add_vec(input logic [3:0] sv, input logic [19:0] sa, input logic [127:0] sd,
                         input logic [3:0] e_rdy, input logic e_wr, input logic [4:0] e_addr,
                         input logic [31:0] e_data);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d_pair;
    logic [127:0] d_all;
    d_pair = {32'h0, 32'hBBBB0000, 32'h0, 32'hAAAA0000};
    d_all  = {32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000};

    // Arbitration table: one record per cycle, registered results checked after the edge.
    add_vec(4'b0101, {5'd0, 5'd6, 5'd0, 5'd5}, d_pair, 4'b0001, 1'b1, 5'd5, 32'hAAAA0000);
    add_vec(4'b0100, {5'd0, 5'd6, 5'd0, 5'd5}, d_pair, 4'b0100, 1'b1, 5'd6, 32'hBBBB0000);
    add_vec(4'b0000, {5'd0, 5'd6, 5'd0, 5'd5}, d_pair, 4'b0000, 1'b0, 5'd6, 32'hBBBB0000);
    add_vec(4'b1000, {5'd8, 15'd0}, {32'h33330000, 96'h0}, 4'b1000, 1'b1, 5'd8, 32'h33330000);
    for (int k = 0; k < 8; k++) begin
      add_vec(4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, d_all, 4'(1 << (k % 4)), 1'b1,
              5'(10 + (k % 4)), 32'h10000000 + 32'(k % 4));
    end
    add_vec(4'b0000, {5'd13, 5'd12, 5'd11, 5'd10}, d_all, 4'b0000, 1'b0, 5'd13, 32'h10000003);

    clr();
    tick();
    tick();
    chk("reset rf_rd_write", 32'(bus.rf_rd_write), 32'd0);
    chk("reset rf_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
    chk("reset rf_rd_data", bus.rf_rd_data, 32'd0);
    chk("reset issue_ready", 32'(issue_ready), 32'd1);
    chk("reset busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
    chk("reset src_ready", 32'(bus.src_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      bus.src_valid   = vecs[i].sv;
      bus.src_rd_addr = vecs[i].sa;
      bus.src_rd_data = vecs[i].sd;
      #1;
      chk($sformatf("vec%0d src_ready", i), 32'(bus.src_ready), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("vec%0d rf_rd_write", i), 32'(bus.rf_rd_write), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d rf_rd_addr", i), 32'(bus.rf_rd_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d rf_rd_data", i), bus.rf_rd_data, vecs[i].e_data);
    end

    // Saturate rd=7, then drain it with three writebacks.
    clr(); issue_valid = 1'b1; issue_rd_addr = 5'd7; rs1_addr = 5'd7;
    #1;
    chk("A1 issue_ready", 32'(issue_ready), 32'd1);
    chk("A1 rd_busy", 32'(rd_busy), 32'd0);
    tick(); #1;
    chk("A2 rd_busy", 32'(rd_busy), 32'd1);
    chk("A2 rs1_busy", 32'(rs1_busy), 32'd1);
    tick(); #1;
    chk("A3 issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0; src(1, 5'd7, 32'h77770001);
    #1;
    chk("A4 issue_ready sat", 32'(issue_ready), 32'd0);
    chk("A4 rd_busy", 32'(rd_busy), 32'd1);
    chk("A4 src_ready", 32'(bus.src_ready), 32'd2);
    tick();
    chk("A4 rf write", {26'd0, bus.rf_rd_write, bus.rf_rd_addr}, {26'd0, 1'b1, 5'd7});
    bus.src_valid = '0;
    #1;
    chk("A5 issue_ready same-edge", 32'(issue_ready), 32'd0);
    tick();
    src(1, 5'd7, 32'h77770002);
    #1;
    chk("A6 issue_ready", 32'(issue_ready), 32'd1);
    chk("A6 rs1_busy", 32'(rs1_busy), 32'd1);
    tick();
    src(1, 5'd7, 32'h77770003);
    #1;
    chk("A7 rs1_busy", 32'(rs1_busy), 32'd1);
    tick();
    bus.src_valid = '0;
    #1;
    chk("A8 rs1_busy", 32'(rs1_busy), 32'd1);
    tick(); #1;
    chk("A9 rs1_busy", 32'(rs1_busy), 32'd0);
    chk("A9 issue_ready", 32'(issue_ready), 32'd1);

    // Increment and decrement of rd=9 on the same edge.
    clr(); issue_valid = 1'b1; issue_rd_addr = 5'd9; rs2_addr = 5'd9; src(0, 5'd9, 32'h99990000);
    #1;
    chk("B1 rs2_busy", 32'(rs2_busy), 32'd0);
    tick();
    bus.src_valid = '0;
    #1;
    chk("B2 rs2_busy", 32'(rs2_busy), 32'd1);
    chk("B2 rf write", {26'd0, bus.rf_rd_write, bus.rf_rd_addr}, {26'd0, 1'b1, 5'd9});
    tick();
    issue_valid = 1'b0; src(0, 5'd9, 32'h99990001);
    #1;
    chk("B3 rs2_busy same-edge", 32'(rs2_busy), 32'd1);
    tick();
    bus.src_valid = '0;
    #1;
    chk("B4 rs2_busy", 32'(rs2_busy), 32'd1);
    tick(); #1;
    chk("B5 rs2_busy drained", 32'(rs2_busy), 32'd0);

    // Write to x0.
    clr(); src(2, 5'd0, 32'hFFFFFFFF);
    #1;
    chk("C src_ready", 32'(bus.src_ready), 32'd4);
    tick();
    chk("C rf_rd_write", 32'(bus.rf_rd_write), 32'd0);
    clr();
    tick();
    chk("C busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
    chk("C issue_ready", 32'(issue_ready), 32'd1);

    // Flush alongside a handshake to rd=3.
    clr(); issue_valid = 1'b1; issue_rd_addr = 5'd3;
    tick();
    issue_rd_addr = 5'd4;
    tick();
    issue_rd_addr = 5'd5; flush = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd4; src(0, 5'd3, 32'h33330003);
    #1;
    chk("D pre busy", {30'd0, rs1_busy, rs2_busy}, 32'd3);
    chk("D src_ready", 32'(bus.src_ready), 32'd1);
    tick();
    flush = 1'b0; issue_valid = 1'b0; bus.src_valid = '0;
    #1;
    chk("D post busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
    chk("D rf write", {26'd0, bus.rf_rd_write, bus.rf_rd_addr}, {26'd0, 1'b1, 5'd3});
    tick();
    issue_rd_addr = 5'd3;
    #1;
    chk("D no underflow busy", {30'd0, rs1_busy, rd_busy}, 32'd0);
    chk("D no underflow ready", 32'(issue_ready), 32'd1);

    // Asynchronous reset in the middle of an output-stage write.
    clr(); issue_valid = 1'b1; issue_rd_addr = 5'd21; src(0, 5'd20, 32'h12340000);
    tick();
    chk("E pre rf_rd_write", 32'(bus.rf_rd_write), 32'd1);
    clr(); issue_rd_addr = 5'd21;
    #1;
    chk("E pre rd_busy", 32'(rd_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("E rst rf_rd_write", 32'(bus.rf_rd_write), 32'd0);
    chk("E rst rf_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
    chk("E rst rf_rd_data", bus.rf_rd_data, 32'd0);
    chk("E rst rd_busy", 32'(rd_busy), 32'd0);
    #2;
    rst_n = 1'b1;
    bus.src_valid = 4'b1111;
    #1;
    chk("E rst ptr", 32'(bus.src_ready), 32'd1);
    clr();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_wb_arbiter.md
# int_wb_arbiter

Writeback arbiter and pending-write scoreboard for the integer register file. Up to NUM_SRC execution units (ALU, load/store, mul/div, CSR) compete for the file's single write port. The block grants one source per cycle in round-robin order and registers the winning write onto the port. It also keeps a per-register pending-write count so the issue stage can detect RAW and WAW hazards on rs1/rs2/rd.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- NUM_SRC, 4, number of writeback requesters
- REG_NUM, 32, number of integer registers; address width is $clog2(REG_NUM)

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- src_valid  input  NUM_SRC  per-source write request
- src_ready  output  NUM_SRC  per-source grant (one-hot or zero)
- src_rd_addr  input  NUM_SRC*5  flattened destination addresses, source i at [5i+4:5i]
- src_rd_data  input  NUM_SRC*DATA_WIDTH  flattened write data
- rf_rd_addr  output  5  to register file int_rd_addr
- rf_rd_data  output  DATA_WIDTH  to register file int_rd_data
- rf_rd_write  output  1  to register file int_rd_write
- issue_valid  input  1  instruction with destination rd is issuing
- issue_rd_addr  input  5  its rd
- issue_ready  output  1  low when the rd pending count is saturated
- rs1_addr, rs2_addr  input  5 each  issue-stage source operands
- rs1_busy, rs2_busy, rd_busy  output  1 each  pending count nonzero for rs1 / rs2 / issue_rd_addr
- flush  input  1  pipeline flush; clears the scoreboard

## Operation
- Arbitration: round-robin starting at priority pointer ptr (reset 0).
  - Grant goes to the first i, in order ptr, ptr+1, ... mod NUM_SRC, with src_valid[i]=1.
  - src_ready[i] is combinational from src_valid and ptr. It is asserted only to the granted source.
  - Handshake: src_valid[i] & src_ready[i].
  - On a handshake, ptr becomes (granted index + 1) mod NUM_SRC. With no request, ptr holds.
- Output stage: on a handshake, the granted addr/data are registered onto rf_rd_addr and rf_rd_data, and rf_rd_write is set to 1.
  - If no handshake occurs, rf_rd_write is 0. rf_rd_addr and rf_rd_data hold their last values.
  - A handshake with rd=0 is accepted, but rf_rd_write stays 0 and no counter changes.
- Scoreboard: 2-bit saturating count per register, count[0] fixed at 0.
  - Increment count[issue_rd_addr] when issue_valid & issue_ready & issue_rd_addr!=0.
  - Decrement count[rf_rd_addr] on the edge that ends a cycle with rf_rd_write=1.
  - Decrement at count 0 is ignored (no underflow).
  - issue_ready = (count[issue_rd_addr] != 3). It is computed purely from the current count, even if a decrement of that register lands on the same edge.
  - rs1_busy, rs2_busy and rd_busy are combinational (count != 0). Address 0 always reads not busy.
- Simultaneous increment and decrement of the same register: net count unchanged.
- Flush: all counts go to 0 at the next edge, and a same-cycle issue increment is discarded.
  - The arbiter and output stage are unaffected: an accepted write still commits, and its decrement saturates at 0.
- Reset (asynchronous, rst_n=0):
  - rf_rd_write=0, rf_rd_addr=0, rf_rd_data=0, ptr=0, all counts 0.
  - Resulting outputs: issue_ready=1, all busy outputs=0, src_ready=0 while no source is valid.
  - An in-flight output-stage write is dropped.

## Timing
- Handshake in cycle N gives rf_rd_write=1 in cycle N+1, so the register file commits at the end of N+1.
- The matching busy flag deasserts in cycle N+2, when the register file already holds the new value. No forwarding path exists; readers stall while busy.
- Issue in cycle M gives busy=1 from cycle M+1.
- Throughput: one write per cycle. A source that holds valid is granted within NUM_SRC cycles (starvation-free).
- No combinational path from src_valid to rf_rd_* outputs.

## Structure
- Package int_wb_pkg:
  - SRC_ALU=0, SRC_LSU=1, SRC_MULDIV=2, SRC_CSR=3
  - NUM_WB_SRC=4
  - typedef logic [1:0] pend_cnt_t
  - PEND_MAX=2'd3
- Sub-module rr_arbiter (NUM_REQ param; ports clk, rst_n, req, advance, grant one-hot, grant_idx) holds ptr. The scoreboard and output stage stay in the top module.

## Test plan
- Reset, then sources 0 and 2 valid with rd=5 (data 0xAAAA0000) and rd=6 (data 0xBBBB0000) → cycle 1: src_ready=0001; cycle 2: src_ready=0100 and rf_rd_write=1 with addr 5 / 0xAAAA0000; cycle 3: addr 6 / 0xBBBB0000.
- All four sources held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3 and rf_rd_write=1 on 8 consecutive cycles.
- Issue rd=7 three times → issue_ready=0 and rd_busy=1; a writeback to 7 gives count 2 two cycles after handshake and issue_ready=1; rs1_addr=7 shows busy until the third writeback.
- Same-edge issue rd=9 and writeback commit to 9 with count 1 → count stays 1 and rs2_busy remains 1.
- Source write to rd=0 with data 0xFFFFFFFF → handshake completes, rf_rd_write stays 0, no busy change.
- Registers 3 and 4 pending, flush asserted in the same cycle as a handshake to rd=3 → next cycle all busy=0 and rf_rd_write=1 for addr 3; the count for 3 stays 0 after commit. rst_n pulsed low mid-write → rf_rd_write=0 immediately.
